// File: rtl/cci_mpf_shim_write_fence_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cci_mpf_shim_write_fence_pkg                                          |
// | Shared types for the write-fence shim and its counter.               |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package cci_mpf_shim_write_fence_pkg;

   localparam int c_DEF_MAX_OUTSTANDING = 256;
   localparam int c_DEF_CNT_BITS        = $clog2(c_DEF_MAX_OUTSTANDING + 1);
   localparam int c_MDATA_BITS          = 13;

   typedef logic [c_MDATA_BITS-1:0]   t_cci_mdata;
   typedef logic [c_DEF_CNT_BITS-1:0] t_write_fence_cnt;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      RESP  = 2'd2
   } t_write_fence_state;

endpackage
`default_nettype wire

// File: rtl/cci_mpf_prim_updown_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cci_mpf_prim_updown_cnt                                               |
// | Saturating counter: one increment, two decrements, optional load.    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module cci_mpf_prim_updown_cnt #(
   parameter int MAX_VAL = 256,
   parameter int W       = $clog2(MAX_VAL + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_inc,
   input  logic         i_dec0,
   input  logic         i_dec1,
   output logic [W-1:0] o_cnt,
   output logic [W-1:0] o_next,
   output logic         o_underflow,
   output logic         o_overflow
);

   logic [W-1:0] r_cnt;
   logic [W:0]   w_up;
   logic [W:0]   w_down;
   logic [W:0]   w_diff;

   // One extra bit lets the +1 and -2 extremes be compared without wrap
   assign w_up        = {1'b0, r_cnt} + {{W{1'b0}}, i_inc};
   assign w_down      = {{W{1'b0}}, i_dec0} + {{W{1'b0}}, i_dec1};
   assign w_diff      = w_up - w_down;
   assign o_underflow = (w_down > w_up);
   assign o_overflow  = !o_underflow && (w_diff > (W+1)'(MAX_VAL));
   assign o_next      = o_underflow ? '0 :
                        o_overflow  ? W'(MAX_VAL) : w_diff[W-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else begin
         r_cnt <= o_next;
      end
   end

   assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/cci_mpf_shim_write_fence.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cci_mpf_shim_write_fence                                              |
// | Write fence over in-order write responses. Optional checking via     |
// | CCI_MPF_SHIM_WRITE_FENCE_CHECK_EN (sticky err_flag + assertions).     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module cci_mpf_shim_write_fence
   import cci_mpf_shim_write_fence_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 256,
   parameter int ALM_FULL_SLACK  = 8,
   parameter int CNT_BITS        = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_wr_req_valid,
   input  logic                i_fence_req_valid,
   input  t_cci_mdata          i_fence_req_mdata,
   output logic                o_fence_ready,
   input  logic                i_c0_wr_rsp_valid,
   input  logic                i_c1_wr_rsp_valid,
   output logic                o_fence_rsp_valid,
   output t_cci_mdata          o_fence_rsp_mdata,
   output logic                o_wr_alm_full,
   output logic [CNT_BITS-1:0] o_outstanding,
   output logic                o_err_flag
);

   t_write_fence_state  r_state;
   logic                r_rsp_valid;
   t_cci_mdata          r_rsp_mdata;
   logic [CNT_BITS-1:0] w_out_next;
   logic [CNT_BITS-1:0] w_drain_next;
   logic [CNT_BITS-1:0] w_drain_cnt;
   logic                w_out_uflow;
   logic                w_out_oflow;
   logic                w_drain_uflow;
   logic                w_drain_oflow;
   logic                w_fence_acc;
   logic                w_in_drain;

   assign w_fence_acc = (r_state == IDLE) && i_fence_req_valid;
   assign w_in_drain  = (r_state == DRAIN);

   cci_mpf_prim_updown_cnt #(.MAX_VAL(MAX_OUTSTANDING), .W(CNT_BITS)) u_outstanding (
      .clk         (clk),
      .reset       (reset),
      .i_load      (1'b0),
      .i_load_val  ({CNT_BITS{1'b0}}),
      .i_inc       (i_wr_req_valid),
      .i_dec0      (i_c0_wr_rsp_valid),
      .i_dec1      (i_c1_wr_rsp_valid),
      .o_cnt       (o_outstanding),
      .o_next      (w_out_next),
      .o_underflow (w_out_uflow),
      .o_overflow  (w_out_oflow)
   );

   // Drain starts at the post-cycle outstanding count, so a write in the
   // fence cycle is ordered ahead of the fence; later writes never count.
   cci_mpf_prim_updown_cnt #(.MAX_VAL(MAX_OUTSTANDING), .W(CNT_BITS)) u_drain (
      .clk         (clk),
      .reset       (reset),
      .i_load      (w_fence_acc),
      .i_load_val  (w_out_next),
      .i_inc       (1'b0),
      .i_dec0      (i_c0_wr_rsp_valid & w_in_drain),
      .i_dec1      (i_c1_wr_rsp_valid & w_in_drain),
      .o_cnt       (w_drain_cnt),
      .o_next      (w_drain_next),
      .o_underflow (w_drain_uflow),
      .o_overflow  (w_drain_oflow)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_rsp_valid <= 1'b0;
         r_rsp_mdata <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_fence_req_valid) begin
                  r_rsp_mdata <= i_fence_req_mdata;
                  if (w_out_next == '0) begin
                     r_state     <= RESP;
                     r_rsp_valid <= 1'b1;
                  end else begin
                     r_state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (w_drain_next == '0) begin
                  r_state     <= RESP;
                  r_rsp_valid <= 1'b1;
               end
            end
            RESP:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_fence_ready     = (r_state == IDLE);
   assign o_fence_rsp_valid = r_rsp_valid;
   assign o_fence_rsp_mdata = r_rsp_mdata;
   assign o_wr_alm_full     = (o_outstanding >= CNT_BITS'(MAX_OUTSTANDING - ALM_FULL_SLACK));

   // A dual response against drain=1 legitimately saturates the drain counter
   logic w_unused_drain;
   assign w_unused_drain = ^{w_drain_cnt, w_drain_uflow, w_drain_oflow};

`ifdef CCI_MPF_SHIM_WRITE_FENCE_CHECK_EN
   logic r_err;
   logic w_bad_fence;

   assign w_bad_fence = i_fence_req_valid && (r_state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_err <= 1'b0;
      end else if (w_out_uflow || w_out_oflow || w_bad_fence) begin
         r_err <= 1'b1;
      end
   end

   assign o_err_flag = r_err;

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!w_out_uflow) else $error("write fence: outstanding underflow");
         assert (!w_out_oflow) else $error("write fence: outstanding overflow");
         assert (!w_bad_fence) else $error("write fence: fence while not ready");
      end
   end
`endif
`else
   assign o_err_flag = 1'b0;

   logic w_unused_chk;
   assign w_unused_chk = ^{w_out_uflow, w_out_oflow};
`endif

endmodule
`default_nettype wire

// File: tb/tb_cci_mpf_shim_write_fence.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cci_mpf_shim_write_fence                                           |
// | Randomized and directed bench against a transaction-level model.     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_cci_mpf_shim_write_fence;

   localparam int MAX = 256;
   localparam int ALM = 248;
`ifdef CCI_MPF_SHIM_WRITE_FENCE_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   typedef struct packed {
      logic        wr;
      logic        c0;
      logic        c1;
      logic        fv;
      logic [12:0] fm;
   } cyc_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_wr_req_valid, i_fence_req_valid, i_c0_wr_rsp_valid, i_c1_wr_rsp_valid;
   logic [12:0] i_fence_req_mdata;
   logic        o_fence_ready, o_fence_rsp_valid, o_wr_alm_full, o_err_flag;
   logic [12:0] o_fence_rsp_mdata;
   logic [8:0]  o_outstanding;

   int errors = 0;
   int checks = 0;

   // Model: write count, and the fence's remaining pre-fence writes
   int          m_out;
   int          m_left;
   bit          m_busy;
   bit          m_resp;
   bit          m_err;
   logic [12:0] m_mdata;

   always #5 clk = ~clk;

   cci_mpf_shim_write_fence dut (
      .clk               (clk),
      .reset             (reset),
      .i_wr_req_valid    (i_wr_req_valid),
      .i_fence_req_valid (i_fence_req_valid),
      .i_fence_req_mdata (i_fence_req_mdata),
      .o_fence_ready     (o_fence_ready),
      .i_c0_wr_rsp_valid (i_c0_wr_rsp_valid),
      .i_c1_wr_rsp_valid (i_c1_wr_rsp_valid),
      .o_fence_rsp_valid (o_fence_rsp_valid),
      .o_fence_rsp_mdata (o_fence_rsp_mdata),
      .o_wr_alm_full     (o_wr_alm_full),
      .o_outstanding     (o_outstanding),
      .o_err_flag        (o_err_flag)
   );

   function automatic cyc_t mk(input logic wr, c0, c1, fv, input logic [12:0] fm);
      cyc_t c;
      c.wr = wr; c.c0 = c0; c.c1 = c1; c.fv = fv; c.fm = fm;
      return c;
   endfunction

   task automatic apply_reset();
      reset = 1'b1;
      i_wr_req_valid = 0; i_fence_req_valid = 0; i_c0_wr_rsp_valid = 0;
      i_c1_wr_rsp_valid = 0; i_fence_req_mdata = '0;
      @(posedge clk); #1;
      reset = 1'b0;
      m_out = 0; m_left = 0; m_busy = 0; m_resp = 0; m_err = 0; m_mdata = '0;
   endtask

   task automatic step(input cyc_t c);
      int sum;
      bit evt;
      i_wr_req_valid    = c.wr;
      i_c0_wr_rsp_valid = c.c0;
      i_c1_wr_rsp_valid = c.c1;
      i_fence_req_valid = c.fv;
      i_fence_req_mdata = c.fm;
      sum = m_out + int'(c.wr) - int'(c.c0) - int'(c.c1);
      evt = (sum < 0) || (sum > MAX) || (c.fv && m_busy);
      if (sum < 0) sum = 0;
      if (sum > MAX) sum = MAX;
      if (!m_busy) begin
         m_resp = 1'b0;
         if (c.fv) begin
            m_busy  = 1'b1;
            m_mdata = c.fm;
            m_left  = sum;
            m_resp  = (sum == 0);
         end
      end else if (m_resp) begin
         m_busy = 1'b0;
         m_resp = 1'b0;
      end else begin
         m_left = m_left - int'(c.c0) - int'(c.c1);
         if (m_left <= 0) begin
            m_left = 0;
            m_resp = 1'b1;
         end
      end
      m_out = sum;
      m_err = m_err | (CHK & evt);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (o_outstanding !== 9'd0) begin errors++; $display("FAIL reset_out: got %0d want 0", o_outstanding); end
      checks++;
      if (o_fence_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_fence_ready); end
      checks++;
      if (o_fence_rsp_valid !== 1'b0 || o_fence_rsp_mdata !== 13'h0) begin
         errors++; $display("FAIL reset_rsp: got v=%b md=%h want v=0 md=0", o_fence_rsp_valid, o_fence_rsp_mdata);
      end
      checks++;
      if (o_err_flag !== 1'b0 || o_wr_alm_full !== 1'b0) begin
         errors++; $display("FAIL reset_flags: got err=%b af=%b want 0 0", o_err_flag, o_wr_alm_full);
      end
   endtask

   task automatic test_idle_fence();
      cyc_t q[$];
      apply_reset();
      q.push_back(mk(0, 0, 0, 1, 13'h0A5));
      q.push_back(mk(0, 0, 0, 0, 13'h0));
      foreach (q[i]) begin
         step(q[i]);
         checks++;
         if ({o_outstanding, o_fence_ready, o_fence_rsp_valid, o_wr_alm_full, o_err_flag} !==
             {9'(m_out), ~m_busy, m_resp, (m_out >= ALM), m_err} || (m_resp && o_fence_rsp_mdata !== m_mdata)) begin
            errors++;
            $display("FAIL idle_fence[%0d]: got out=%0d rdy=%b rv=%b md=%h want out=%0d rdy=%b rv=%b md=%h",
                     i, o_outstanding, o_fence_ready, o_fence_rsp_valid, o_fence_rsp_mdata, m_out, ~m_busy, m_resp, m_mdata);
         end
         if (i == 0) begin
            checks++;
            if (o_fence_rsp_valid !== 1'b1 || o_fence_rsp_mdata !== 13'h0A5) begin
               errors++; $display("FAIL idle_fence_rsp: got v=%b md=%h want v=1 md=0a5", o_fence_rsp_valid, o_fence_rsp_mdata);
            end
         end else begin
            checks++;
            if (o_fence_ready !== 1'b1 || o_fence_rsp_valid !== 1'b0) begin
               errors++; $display("FAIL idle_fence_after: got rdy=%b v=%b want 1 0", o_fence_ready, o_fence_rsp_valid);
            end
         end
      end
   endtask

   // Plays writes, a fence, optional post-fence writes and c1 responses
   task automatic test_drain(input int n_pre, input int n_post, input logic [12:0] md,
                             input int want_idx, input int want_out);
      cyc_t q[$];
      int rsp_idx = -1;
      int out_at  = -1;
      apply_reset();
      for (int k = 0; k < n_pre; k++) q.push_back(mk(1, 0, 0, 0, 13'h0));
      q.push_back(mk(0, 0, 0, 1, md));
      for (int k = 0; k < n_post; k++) q.push_back(mk(1, 0, 0, 0, 13'h0));
      for (int k = 0; k < n_pre + n_post; k++) q.push_back(mk(0, 0, 1, 0, 13'h0));
      q.push_back(mk(0, 0, 0, 0, 13'h0));
      foreach (q[i]) begin
         step(q[i]);
         checks++;
         if ({o_outstanding, o_fence_ready, o_fence_rsp_valid, o_wr_alm_full, o_err_flag} !==
             {9'(m_out), ~m_busy, m_resp, (m_out >= ALM), m_err} || (m_resp && o_fence_rsp_mdata !== m_mdata)) begin
            errors++;
            $display("FAIL drain[%0d]: got out=%0d rdy=%b rv=%b md=%h want out=%0d rdy=%b rv=%b md=%h",
                     i, o_outstanding, o_fence_ready, o_fence_rsp_valid, o_fence_rsp_mdata, m_out, ~m_busy, m_resp, m_mdata);
         end
         if (o_fence_rsp_valid === 1'b1 && rsp_idx < 0) begin
            rsp_idx = i;
            out_at  = int'(o_outstanding);
         end
      end
      checks++;
      if (rsp_idx != want_idx || out_at != want_out) begin
         errors++; $display("FAIL drain_timing: got idx=%0d out=%0d want idx=%0d out=%0d", rsp_idx, out_at, want_idx, want_out);
      end
   endtask

   task automatic test_dual();
      cyc_t q[$];
      int rsp_idx[$];
      apply_reset();
      for (int k = 0; k < 4; k++) q.push_back(mk(1, 0, 0, 0, 13'h0));
      q.push_back(mk(1, 0, 0, 1, 13'h1F0));
      q.push_back(mk(0, 1, 1, 0, 13'h0));
      q.push_back(mk(0, 1, 1, 0, 13'h0));
      q.push_back(mk(0, 0, 1, 0, 13'h0));
      q.push_back(mk(0, 0, 0, 0, 13'h0));
      q.push_back(mk(1, 0, 0, 0, 13'h0));
      q.push_back(mk(0, 0, 0, 1, 13'h0C3));
      q.push_back(mk(1, 0, 0, 0, 13'h0));
      q.push_back(mk(0, 1, 1, 0, 13'h0));
      q.push_back(mk(0, 0, 0, 0, 13'h0));
      foreach (q[i]) begin
         step(q[i]);
         checks++;
         if ({o_outstanding, o_fence_ready, o_fence_rsp_valid, o_wr_alm_full, o_err_flag} !==
             {9'(m_out), ~m_busy, m_resp, (m_out >= ALM), m_err} || (m_resp && o_fence_rsp_mdata !== m_mdata)) begin
            errors++;
            $display("FAIL dual[%0d]: got out=%0d rdy=%b rv=%b md=%h want out=%0d rdy=%b rv=%b md=%h",
                     i, o_outstanding, o_fence_ready, o_fence_rsp_valid, o_fence_rsp_mdata, m_out, ~m_busy, m_resp, m_mdata);
         end
         if (o_fence_rsp_valid === 1'b1) rsp_idx.push_back(i);
      end
      checks++;
      if (rsp_idx.size() != 2 || rsp_idx[0] != 7 || rsp_idx[1] != 12 || o_outstanding !== 9'd0) begin
         errors++; $display("FAIL dual_timing: got n=%0d out=%0d want responses at 7,12 out=0", rsp_idx.size(), o_outstanding);
      end
   endtask

   task automatic test_alm_full();
      cyc_t q[$];
      logic a247, a248, a_after;
      apply_reset();
      for (int k = 0; k < 248; k++) q.push_back(mk(1, 0, 0, 0, 13'h0));
      q.push_back(mk(0, 1, 0, 0, 13'h0));
      for (int k = 0; k < 10; k++) q.push_back(mk(1, 0, 0, 0, 13'h0));
      foreach (q[i]) begin
         step(q[i]);
         checks++;
         if ({o_outstanding, o_fence_ready, o_fence_rsp_valid, o_wr_alm_full, o_err_flag} !==
             {9'(m_out), ~m_busy, m_resp, (m_out >= ALM), m_err}) begin
            errors++;
            $display("FAIL alm[%0d]: got out=%0d af=%b err=%b want out=%0d af=%b err=%b",
                     i, o_outstanding, o_wr_alm_full, o_err_flag, m_out, (m_out >= ALM), m_err);
         end
         if (i == 246) a247 = o_wr_alm_full;
         if (i == 247) a248 = o_wr_alm_full;
         if (i == 248) a_after = o_wr_alm_full;
      end
      checks++;
      if ({a247, a248, a_after} !== 3'b010) begin
         errors++; $display("FAIL alm_edges: got %b%b%b want 010", a247, a248, a_after);
      end
      checks++;
      if (o_outstanding !== 9'd256 || o_err_flag !== CHK) begin
         errors++; $display("FAIL overflow_sat: got out=%0d err=%b want out=256 err=%b", o_outstanding, o_err_flag, CHK);
      end
   endtask

   task automatic test_reset_mid_drain();
      cyc_t q[$];
      apply_reset();
      for (int k = 0; k < 10; k++) q.push_back(mk(1, 0, 0, 0, 13'h0));
      q.push_back(mk(0, 0, 0, 1, 13'h077));
      q.push_back(mk(0, 0, 1, 0, 13'h0));
      foreach (q[i]) step(q[i]);
      checks++;
      if (o_fence_ready !== 1'b0 || o_outstanding !== 9'd9) begin
         errors++; $display("FAIL mid_drain_pre: got rdy=%b out=%0d want 0 9", o_fence_ready, o_outstanding);
      end
      apply_reset();
      checks++;
      if (o_outstanding !== 9'd0 || o_fence_ready !== 1'b1 || o_fence_rsp_valid !== 1'b0) begin
         errors++; $display("FAIL mid_drain_reset: got out=%0d rdy=%b v=%b want 0 1 0", o_outstanding, o_fence_ready, o_fence_rsp_valid);
      end
      for (int k = 0; k < 4; k++) begin
         step(mk(0, 0, 0, 0, 13'h0));
         checks++;
         if (o_fence_rsp_valid !== 1'b0 || o_fence_ready !== 1'b1) begin
            errors++; $display("FAIL mid_drain_quiet[%0d]: got v=%b rdy=%b want 0 1", k, o_fence_rsp_valid, o_fence_ready);
         end
      end
   endtask

   task automatic test_underflow();
      apply_reset();
      step(mk(0, 1, 0, 0, 13'h0));
      checks++;
      if (o_outstanding !== 9'd0 || o_err_flag !== CHK) begin
         errors++; $display("FAIL underflow: got out=%0d err=%b want 0 %b", o_outstanding, o_err_flag, CHK);
      end
      step(mk(1, 1, 1, 0, 13'h0));
      step(mk(0, 0, 0, 0, 13'h0));
      checks++;
      if (o_outstanding !== 9'd0 || o_err_flag !== CHK) begin
         errors++; $display("FAIL underflow_sticky: got out=%0d err=%b want 0 %b", o_outstanding, o_err_flag, CHK);
      end
      apply_reset();
      checks++;
      if (o_err_flag !== 1'b0) begin errors++; $display("FAIL underflow_clear: got err=%b want 0", o_err_flag); end
   endtask

   task automatic test_random();
      cyc_t c;
      apply_reset();
      for (int i = 0; i < 800; i++) begin
         c.wr = 1'($urandom_range(0, 1));
         c.c0 = (m_out >= 1) && ($urandom_range(0, 2) == 0);
         c.c1 = (m_out >= 1 + int'(c.c0)) && ($urandom_range(0, 2) == 0);
         c.fv = !m_busy && ($urandom_range(0, 5) == 0);
         c.fm = 13'($urandom);
         step(c);
         checks++;
         if ({o_outstanding, o_fence_ready, o_fence_rsp_valid, o_wr_alm_full, o_err_flag} !==
             {9'(m_out), ~m_busy, m_resp, (m_out >= ALM), m_err} || (m_resp && o_fence_rsp_mdata !== m_mdata)) begin
            errors++;
            $display("FAIL random[%0d]: got out=%0d rdy=%b rv=%b md=%h want out=%0d rdy=%b rv=%b md=%h",
                     i, o_outstanding, o_fence_ready, o_fence_rsp_valid, o_fence_rsp_mdata, m_out, ~m_busy, m_resp, m_mdata);
         end
      end
   endtask

   initial begin
      test_reset();
      test_idle_fence();
      test_drain(5, 0, 13'h123, 10, 0);
      test_drain(3, 4, 13'h0F1, 10, 4);
      test_dual();
      test_alm_full();
      test_reset_mid_drain();
      test_underflow();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
